seq_fixed_point_sqrt: RTL and testbench



---
 rtl/seq_fixed_point_sqrt.sv | 209 ++++++++++++++++++++
 tb/tb_seq_fixed_point_sqrt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fixed_point_sqrt.sv
// Multi-cycle signed fixed-point square root, one root bit per clock.
// Optional o_exact output enabled by defining SEQ_FIXED_POINT_SQRT_EXACT_EN.
module seq_fixed_point_sqrt #(
    parameter int WII   = 10,
    parameter int WIF   = 11,
    parameter int WOI   = 9,
    parameter int WOF   = 10,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WII+WIF-1:0]   in,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 o_overflow,
    output logic                 o_neg
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
    ,
    output logic                 o_exact
`endif
);

    localparam int IW  = WII + WIF;
    localparam int WR  = WOI + WOF;
    localparam int NI  = WR + ROUND;
    localparam int NI1 = NI + 1;
    localparam int SH  = 2 * WOF + 2 * ROUND - WIF;
    localparam int XW  = IW + 2 * NI + 2;
    localparam int RW  = NI + 2;
    localparam int CW  = (NI > 1) ? $clog2(NI) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Largest positive output value, widened to the rounded-root width.
    localparam logic [NI:0] MAXP = {{(NI + 2 - WR){1'b0}}, {(WR - 1){1'b1}}};
    localparam logic [CW-1:0] CNT_LOAD = CW'(NI - 1);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2*NI-1:0] rad;
    logic [RW-1:0]   rem;
    logic [NI-1:0]   root;
    logic            neg_r;
    logic            ovf_r;

    logic            accept;
    logic            in_neg;
    logic [XW-1:0]   in_ext;
    logic [XW-1:0]   r_ext;
    logic            lost_hi;

    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   trial;
    logic [RW-1:0]   diff;
    logic            ge;
    logic [RW-1:0]   rem_nxt;
    logic [NI-1:0]   root_nxt;
    logic [2*NI-1:0] rad_nxt;

    logic [NI:0]     rnd;
    logic            sat;
    logic [WR-1:0]   res;

`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
    logic            trunc;
    logic            trunc_r;
    logic            round_inc;
    logic            exact_d;
`endif

    assign in_neg = in[IW-1];
    assign in_ext = {{(XW - IW){1'b0}}, in};

    // Ready when idle, or when the held result is being taken this cycle.
    assign i_ready = (state == S_IDLE) | (o_valid & o_ready);
    assign accept  = i_valid & i_ready;

    // Align the radicand so the root lands with WOF (+ROUND) fraction bits.
    generate
        if (SH >= 0) begin : g_shl
            assign r_ext = in_ext << SH;
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
            assign trunc = 1'b0;
`endif
        end else begin : g_shr
            assign r_ext = in_ext >> (-SH);
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
            localparam logic [XW-1:0] ONE_X = {{(XW - 1){1'b0}}, 1'b1};
            assign trunc = |(in_ext & ((ONE_X << (-SH)) - ONE_X));
`endif
        end
    endgenerate

    assign lost_hi = |r_ext[XW-1:2*NI];

    // One restoring step: bring in two radicand bits, try (root<<2)|1.
    assign rem_sh   = (rem << 2) | RW'(rad[2*NI-1 -: 2]);
    assign trial    = (RW'(root) << 2) | RW'(1);
    assign ge       = rem_sh >= trial;
    assign diff     = rem_sh - trial;
    assign rem_nxt  = ge ? diff : rem_sh;
    assign root_nxt = (root << 1) | NI'(ge);
    assign rad_nxt  = rad << 2;

    // Drop the guard bit with round-half-up, keeping a carry bit.
    generate
        if (ROUND != 0) begin : g_rnd
            assign rnd = NI1'(root >> 1) + NI1'(root[0]);
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
            assign round_inc = root[0];
`endif
        end else begin : g_trn
            assign rnd = NI1'(root);
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
            assign round_inc = 1'b0;
`endif
        end
    endgenerate

    assign sat = (rnd > MAXP) | ovf_r;
    assign res = sat ? MAXP[WR-1:0] : rnd[WR-1:0];

`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
    assign exact_d = (rem == '0) & ~round_inc & ~trunc_r & ~neg_r;
`endif

    // Control FSM plus iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rad        <= '0;
            rem        <= '0;
            root       <= '0;
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
            o_valid    <= 1'b0;
            out        <= '0;
            o_overflow <= 1'b0;
            o_neg      <= 1'b0;
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
            trunc_r    <= 1'b0;
            o_exact    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        o_valid <= 1'b0;
                        rem     <= '0;
                        root    <= '0;
                        cnt     <= CNT_LOAD;
                        rad     <= r_ext[2*NI-1:0];
                        if (in_neg) begin
                            neg_r <= 1'b1;
                            ovf_r <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            neg_r <= 1'b0;
                            ovf_r <= lost_hi;
                            state <= S_CALC;
                        end
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
                        trunc_r <= trunc;
`endif
                    end else if (state == S_DONE) begin
                        if (!o_valid) begin
                            o_valid <= 1'b1;
                            if (neg_r) begin
                                out        <= '0;
                                o_overflow <= 1'b0;
                                o_neg      <= 1'b1;
                            end else begin
                                out        <= res;
                                o_overflow <= sat;
                                o_neg      <= 1'b0;
                            end
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
                            o_exact <= exact_d;
`endif
                        end else if (o_ready) begin
                            o_valid <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_CALC: begin
                    rad  <= rad_nxt;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fixed_point_sqrt.sv
// Directed bench for seq_fixed_point_sqrt: vector table plus handshake,
// overflow and reset-abort sequences.
module tb_seq_fixed_point_sqrt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [20:0] in = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [18:0] out;
    logic        o_overflow;
    logic        o_neg;

    logic        i_valid2 = 1'b0;
    logic        i_ready2;
    logic [20:0] in2 = '0;
    logic        o_valid2;
    logic        o_ready2 = 1'b0;
    logic [12:0] out2;
    logic        o_overflow2;
    logic        o_neg2;

`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
    logic        o_exact;
    logic        o_exact2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_fixed_point_sqrt dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .in         (in),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .out        (out),
        .o_overflow (o_overflow),
        .o_neg      (o_neg)
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
        ,
        .o_exact    (o_exact)
`endif
    );

    seq_fixed_point_sqrt #(.WOI(3)) dut_ovf (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid2),
        .i_ready    (i_ready2),
        .in         (in2),
        .o_valid    (o_valid2),
        .o_ready    (o_ready2),
        .out        (out2),
        .o_overflow (o_overflow2),
        .o_neg      (o_neg2)
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
        ,
        .o_exact    (o_exact2)
`endif
    );

    typedef struct {
        logic [20:0] din;
        logic [18:0] dout;
        logic        ovf;
        logic        neg;
        int          lat;
        logic        exact;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one operand at a negedge and check the result and latency.
    task automatic run_op(input string nm, input vec_t v, input bit early);
        int lat;
        chk({nm, "_rdy_pre"}, 32'(i_ready), 32'd1);
        i_valid = 1'b1;
        in      = v.din;
        o_ready = early;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
        chk({nm, "_out"}, 32'(out), 32'(v.dout));
        chk({nm, "_ovf"}, 32'(o_overflow), 32'(v.ovf));
        chk({nm, "_neg"}, 32'(o_neg), 32'(v.neg));
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
        chk({nm, "_exact"}, 32'(o_exact), 32'(v.exact));
`endif
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        chk({nm, "_vld_clr"}, 32'(o_valid), 32'd0);
        chk({nm, "_rdy_post"}, 32'(i_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{21'h002000, 19'h00800, 1'b0, 1'b0, 21, 1'b1};
        vecs[1] = '{21'h001000, 19'h005A8, 1'b0, 1'b0, 21, 1'b0};
        vecs[2] = '{21'h1FF800, 19'h00000, 1'b0, 1'b1, 1,  1'b0};
        vecs[3] = '{21'h000000, 19'h00000, 1'b0, 1'b0, 21, 1'b1};
        vecs[4] = '{21'h000001, 19'h00017, 1'b0, 1'b0, 21, 1'b0};
        vecs[5] = '{21'h001800, 19'h006EE, 1'b0, 1'b0, 21, 1'b0};
        vecs[6] = '{21'h0FFFFF, 19'h05A82, 1'b0, 1'b0, 21, 1'b0};
        vecs[7] = '{21'h004800, 19'h00C00, 1'b0, 1'b0, 21, 1'b1};
        vecs[8] = '{21'h000200, 19'h00200, 1'b0, 1'b0, 21, 1'b1};
        vecs[9] = '{21'h100000, 19'h00000, 1'b0, 1'b1, 1,  1'b0};

        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(i_ready), 32'd1);
        chk("rst_vld", 32'(o_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_neg", 32'(o_neg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("v%0d", i), vecs[i], (i % 3) == 2);
        end

        // Saturation in the narrow-output instance.
        i_valid2 = 1'b1;
        in2      = 21'h008000;
        @(posedge clk);
        @(negedge clk);
        i_valid2 = 1'b0;
        lat = 0;
        while (!o_valid2 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("ovf_lat", 32'(lat), 32'd15);
        chk("ovf_out", 32'(out2), 32'h0FFF);
        chk("ovf_flag", 32'(o_overflow2), 32'd1);
        chk("ovf_neg", 32'(o_neg2), 32'd0);
`ifdef SEQ_FIXED_POINT_SQRT_EXACT_EN
        chk("ovf_exact", 32'(o_exact2), 32'd1);
`endif
        o_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready2 = 1'b0;
        chk("ovf_vld_clr", 32'(o_valid2), 32'd0);

        // Back-pressure: result held, new operand waits for o_ready.
        i_valid = 1'b1;
        in      = 21'h004800;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        chk("bp_calc_rdy", 32'(i_ready), 32'd0);
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp_lat", 32'(lat), 32'd21);
        i_valid = 1'b1;
        in      = 21'h000800;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold_out%0d", k), 32'(out), 32'h00C00);
            chk($sformatf("bp_hold_vld%0d", k), 32'(o_valid), 32'd1);
            chk($sformatf("bp_hold_rdy%0d", k), 32'(i_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_rdy_pass", 32'(i_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b0;
        chk("bp_vld_drop", 32'(o_valid), 32'd0);
        chk("bp_busy", 32'(i_ready), 32'd0);
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp2_lat", 32'(lat), 32'd21);
        chk("bp2_out", 32'(out), 32'h00400);
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        chk("bp2_rdy", 32'(i_ready), 32'd1);

        // Reset five cycles into an iteration aborts it.
        i_valid = 1'b1;
        in      = 21'h002000;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ab_rdy", 32'(i_ready), 32'd1);
        chk("ab_vld", 32'(o_valid), 32'd0);
        chk("ab_out", 32'(out), 32'd0);
        chk("ab_ovf", 32'(o_overflow), 32'd0);
        chk("ab_neg", 32'(o_neg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("ab_no_result", 32'(seen), 32'd0);
        run_op("ab_next", '{21'h000200, 19'h00200, 1'b0, 1'b0, 21, 1'b1}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
